pong_match_ctrl: RTL
====================

# pong_match_ctrl

Parametrised match controller for the Pong game: the next generation of the top-level game FSM. It supports 2–4 players, selectable ball-count or first-to-score match mode, a pause state, and a frame-tick-driven serve/game-over delay with saturating per-player scores. It sits between the VGA/animation blocks (which supply `miss` and `frame_tick`) and the text renderer (which consumes scores, balls left and winner). It drives `stop` to the animation block.

## Interface
Parameters:
- `NPLAYERS`, 2: number of players, legal 2..4.
- `SCORE_W`, 3: width of each player score.
- `BALLS`, 3: serves per game in ball-count mode, legal 1..15.
- `WIN_SCORE`, 5: target score in first-to-score mode, legal 1..2^SCORE_W-1.
- `DELAY_TICKS`, 120: frame ticks of rest in SERVE and OVER, legal 1..255.

Ports:
- `clk_out`  in  1  system clock (25 MHz pixel clock).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `key`  in  2*NPLAYERS  player buttons, active-low; `key[2i+1:2i]` belongs to player i.
- `miss`  in  NPLAYERS  1-cycle pulse; bit i means player i missed the ball.
- `frame_tick`  in  1  1-cycle pulse, once per frame.
- `pause_btn`  in  1  1-cycle pulse that toggles pause.
- `mode`  in  1  0 = ball-count match, 1 = first to WIN_SCORE.
- `state`  out  3  0 NEWGAME, 1 PLAY, 2 SERVE, 3 PAUSE, 4 OVER.
- `stop`  out  1  freezes the animation; high in every state except PLAY.
- `scores`  out  NPLAYERS*SCORE_W  flat scores; player i occupies `[i*SCORE_W +: SCORE_W]`.
- `balls_left`  out  4  serves remaining after the current one.
- `winner`  out  2  player index of the winner; valid only while `winner_valid` is high.
- `winner_valid`  out  1  high in OVER.
- `tie`  out  1  high in OVER when two or more players share the maximum score.
- `timer_up`  out  1  high when the delay counter is 0.

## Operation
- The state is held in a registered FSM. Scores, `balls_left`, the latched mode and the delay counter are all registered.
- `any_key` is true when `key != all ones`.
- **NEWGAME:**
  - Hold scores at 0 and `balls_left` at BALLS.
  - On `any_key`: latch `mode` into `mode_q`, set `balls_left = BALLS-1`, go to PLAY.
- **PLAY:**
  - A miss has priority over `pause_btn`.
  - When `miss != 0`: every player whose `miss` bit is 0 gains +1. Scores saturate at 2^SCORE_W-1. If all bits are set, no score changes.
  - The next state is OVER if either condition holds:
    - `mode_q = 0` and `balls_left == 0`;
    - `mode_q = 1` and any updated score ≥ WIN_SCORE.
  - Otherwise the next state is SERVE. In that case `balls_left` decrements only when `mode_q = 0`.
  - Either way, the delay counter loads DELAY_TICKS.
  - Else, if `pause_btn` is set, go to PAUSE.
- **SERVE:** when `timer_up` and `any_key`, go to PLAY. `miss` and `pause_btn` are ignored.
- **PAUSE:** `pause_btn` returns to PLAY. Misses are ignored and the counter is untouched.
- **OVER:**
  - `winner` is the lowest index holding the maximum score. `tie` is set if that maximum is shared.
  - When `timer_up`, go to NEWGAME.
- **Delay counter:**
  - 8 bits wide.
  - Loads on the PLAY→SERVE or PLAY→OVER edge.
  - Decrements on `frame_tick` while nonzero in SERVE or OVER.
  - `timer_up = (count == 0)`.
- Unused encodings 5–7 return to NEWGAME on the next clock.

## Timing
- Reset values (asynchronous):
  - `state` 0, `stop` 1.
  - scores 0, `balls_left` BALLS.
  - counter 0, so `timer_up` is 1.
  - `winner` 0, `winner_valid` 0, `tie` 0, `mode_q` 0.
- A `miss` pulse sampled at edge N produces the new scores, `state` and `balls_left` visible after edge N. This is one-cycle latency.
- `stop`, `winner_valid` and `tie` are decoded from the registered state and scores, so they have no added latency.
- A miss coinciding with the load cycle is handled as specified in PLAY. A `frame_tick` on the load cycle does not decrement the counter.
- The SERVE/OVER dwell is exactly DELAY_TICKS `frame_tick` pulses. Leaving SERVE also requires `any_key` on or after the cycle in which `timer_up` rises.
- `mode` changes are ignored outside NEWGAME.
- Reset asserted mid-game forces all outputs to their reset values immediately; play resumes from NEWGAME.

## Test plan
- **Ball-count match, 2 players, BALLS=3, DELAY_TICKS=2:**
  - Stimulus: reset, press `key[0]`, then apply `miss=01`, `miss=10`, `miss=01`, pressing a key after each serve delay.
  - Required: `balls_left` goes 2→1→0. Scores end at {p0=1, p1=2}, reaching OVER on the 3rd miss. Then `winner=1`, `tie=0`, and NEWGAME follows 2 ticks later.
- **First-to-score, WIN_SCORE=2:**
  - Stimulus: `mode=1`, player 0 misses twice.
  - Required: `balls_left` stays 2, p1 reaches 2, the FSM goes to OVER, `winner=1`.
- **Saturation and simultaneous misses, 3 players:**
  - Stimulus: `miss=011` repeatedly, with SCORE_W=2 and ball count sufficient.
  - Required: only p2 increments, saturating at 3. `miss=111` changes no score but still consumes a ball.
- **Pause:**
  - Stimulus: `pause_btn` in PLAY, then `miss` while paused, then `pause_btn` again.
  - Required: `state` 3 with `stop=1`; scores unchanged during pause; `state` returns to 1.
- **Miss/pause collision:**
  - Stimulus: `miss` and `pause_btn` in the same cycle.
  - Required: goes to SERVE and the score updates; no pause is entered.
- **Reset in SERVE:**
  - Stimulus: with the counter mid-count, assert `rst_n=0`.
  - Required: `state=0`, scores 0, `balls_left=3`, `timer_up=1` asynchronously.

Source files
------------

// File: rtl/pong_match_ctrl_if.sv
// Pong match controller bus: player inputs, frame events
// and the scoreboard outputs consumed by the text renderer.
interface pong_match_ctrl_if #(
  parameter int NPLAYERS = 2,
  parameter int SCORE_W  = 3
);
  logic [2*NPLAYERS-1:0]       key;
  logic [NPLAYERS-1:0]         miss;
  logic                        frame_tick;
  logic                        pause_btn;
  logic                        mode;
  logic [2:0]                  state;
  logic                        stop;
  logic [NPLAYERS*SCORE_W-1:0] scores;
  logic [3:0]                  balls_left;
  logic [1:0]                  winner;
  logic                        winner_valid;
  logic                        tie;
  logic                        timer_up;

  modport master (
    output key, miss, frame_tick,
    output pause_btn, mode,
    input  state, stop, scores,
    input  balls_left, winner,
    input  winner_valid, tie, timer_up
  );

  modport slave (
    input  key, miss, frame_tick,
    input  pause_btn, mode,
    output state, stop, scores,
    output balls_left, winner,
    output winner_valid, tie, timer_up
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match FSM: 2-4 players, ball-count or first-to-score,
// pause, frame-tick serve/game-over delay, saturating scores.
module pong_match_ctrl #(
  parameter int NPLAYERS    = 2,
  parameter int SCORE_W     = 3,
  parameter int BALLS       = 3,
  parameter int WIN_SCORE   = 5,
  parameter int DELAY_TICKS = 120
) (
  input logic              clk_out,
  input logic              rst_n,
  pong_match_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    NEWGAME = 3'd0,
    PLAY    = 3'd1,
    SERVE   = 3'd2,
    PAUSE   = 3'd3,
    OVER    = 3'd4
  } st_t;

  localparam int SW = NPLAYERS * SCORE_W;
  localparam logic [SCORE_W-1:0] SMAX = '1;
  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);
  localparam logic [3:0] BALLS0 = 4'(BALLS);
  localparam logic [3:0] BALLS1 = 4'(BALLS - 1);
  localparam logic [7:0] DT = 8'(DELAY_TICKS);

  st_t          st_q, st_d;
  logic [SW-1:0] sc_q, sc_d, sc_inc;
  logic [3:0]   balls_q, balls_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic         any_key, tup, hit_win;
  logic [SCORE_W-1:0] best;
  logic [1:0]   win_idx;
  logic [2:0]   nbest;

  assign any_key = bus.key != '1;
  assign tup     = cnt_q == 8'd0;

  always_comb begin
    sc_inc  = sc_q;
    hit_win = 1'b0;
    for (int i = 0; i < NPLAYERS; i++) begin
      if (!bus.miss[i] &&
          sc_q[i*SCORE_W +: SCORE_W] != SMAX)
        sc_inc[i*SCORE_W +: SCORE_W] =
          sc_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
      if (sc_inc[i*SCORE_W +: SCORE_W] >= WIN)
        hit_win = 1'b1;
    end
  end

  // strict '>' keeps the lowest index among equal maxima
  always_comb begin
    best    = sc_q[SCORE_W-1:0];
    win_idx = 2'd0;
    nbest   = 3'd0;
    for (int i = 1; i < NPLAYERS; i++) begin
      if (sc_q[i*SCORE_W +: SCORE_W] > best) begin
        best    = sc_q[i*SCORE_W +: SCORE_W];
        win_idx = 2'(i);
      end
    end
    for (int i = 0; i < NPLAYERS; i++) begin
      if (sc_q[i*SCORE_W +: SCORE_W] == best)
        nbest = nbest + 3'd1;
    end
  end

  always_comb begin
    st_d    = st_q;
    sc_d    = sc_q;
    balls_d = balls_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if ((st_q == SERVE || st_q == OVER) &&
        bus.frame_tick && !tup)
      cnt_d = cnt_q - 8'd1;
    unique case (st_q)
      NEWGAME: begin
        if (any_key) begin
          mode_d  = bus.mode;
          balls_d = BALLS1;
          st_d    = PLAY;
        end
      end
      PLAY: begin
        if (bus.miss != '0) begin
          sc_d  = sc_inc;
          cnt_d = DT;
          if ((!mode_q && balls_q == 4'd0) ||
              (mode_q && hit_win)) begin
            st_d = OVER;
          end else begin
            st_d = SERVE;
            if (!mode_q)
              balls_d = balls_q - 4'd1;
          end
        end else if (bus.pause_btn) begin
          st_d = PAUSE;
        end
      end
      SERVE: if (tup && any_key) st_d = PLAY;
      PAUSE: if (bus.pause_btn) st_d = PLAY;
      OVER:  if (tup) st_d = NEWGAME;
      default: st_d = NEWGAME;
    endcase
    // NEWGAME always shows a fresh scoreboard
    if (st_d == NEWGAME) begin
      sc_d    = '0;
      balls_d = BALLS0;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= NEWGAME;
      sc_q    <= '0;
      balls_q <= BALLS0;
      cnt_q   <= 8'd0;
      mode_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      sc_q    <= sc_d;
      balls_q <= balls_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.state        = st_q;
  assign bus.stop         = st_q != PLAY;
  assign bus.scores       = sc_q;
  assign bus.balls_left   = balls_q;
  assign bus.timer_up     = tup;
  assign bus.winner_valid = st_q == OVER;
  assign bus.winner       =
    (st_q == OVER) ? win_idx : 2'd0;
  assign bus.tie          =
    (st_q == OVER) && (nbest > 3'd1);
endmodule
